// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states, default sizes
// and the mode-0 clock constants used by both link ends.
package spi_pkg;
  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a history flop that yields
// single-cycle rise/fall strobes in the i_clk domain.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;
endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI responder: oversampled SCLK/CS_n/MOSI, byte RX
// pulse interface and a single-entry TX holding buffer.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx_underrun,
  output logic                  o_busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_unused_lvl;
  logic w_cs_rise, w_cs_fall, w_cs_unused_lvl;
  logic w_mosi, w_mosi_unused_rise, w_mosi_unused_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
    .o_level(w_sclk_unused_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs_n),
    .o_level(w_cs_unused_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_unused_rise), .o_fall(w_mosi_unused_fall)
  );

  // Sample/drive edges follow the shared mode constants.
  logic w_sample, w_drive;
  assign w_sample = (CPOL == CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_drive  = (CPOL == CPHA) ? w_sclk_fall : w_sclk_rise;

  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_tx_shift, r_buf, r_rx_data;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [CW-1:0]         r_cnt;
  logic r_buf_full, r_done, r_rx_valid, r_underrun;
  logic w_load, w_rx_shift, w_tx_shift, w_enter, w_exit, w_accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_rx_shift = 1'b0;
    w_tx_shift = 1'b0;
    w_enter    = 1'b0;
    w_exit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_next  = SHIFT;
          w_load  = 1'b1;
          w_enter = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_next = IDLE;
          w_exit = 1'b1;
        end else if (w_sample) begin
          w_rx_shift = 1'b1;
        end else if (w_drive) begin
          if (r_cnt == '0 && r_done) w_load = 1'b1;
          else                       w_tx_shift = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = i_tx_valid & ~r_buf_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_shift <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if (w_load) begin
        if (r_buf_full) begin
          r_tx_shift <= r_buf;
        end else begin
          r_tx_shift <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_tx_shift) begin
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end else if (w_exit) begin
        r_tx_shift <= '0;
      end
      // A same-cycle write lands after the load has seen the old state.
      if (w_accept) begin
        r_buf      <= i_tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
      if (w_enter) begin
        r_cnt      <= '0;
        r_done     <= 1'b0;
        r_rx_shift <= '0;
      end
      if (w_rx_shift) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], w_mosi};
        if (r_cnt == LAST) begin
          r_cnt      <= '0;
          r_done     <= 1'b1;
          r_rx_data  <= {r_rx_shift, w_mosi};
          r_rx_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_miso        = r_tx_shift[DATA_WIDTH-1];
  assign o_miso_oe     = (r_state == SHIFT);
  assign o_busy        = (r_state == SHIFT);
  assign o_tx_ready    = ~r_buf_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_underrun;
endmodule
